// File: rtl/result_bus_arbiter_if.sv
// Result uop / branch types and the source-side and bus-side bundle of result_bus_arbiter.
// The arbiter uses the slave modport; whoever feeds sources and watches the buses uses master.
package result_bus_pkg;
  localparam int SQN_W = 7;

  typedef struct packed {
    logic [6:0]       tagDst;
    logic [5:0]       nmDst;
    logic [SQN_W-1:0] sqN;
    logic [31:0]      result;
    logic [3:0]       flags;
  } RES_UOp;

  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqN;
  } BranchProv;
endpackage

interface result_bus_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_BUS = 2
);
  import result_bus_pkg::*;

  logic [NUM_SRC-1:0] IN_valid;
  RES_UOp             IN_res [NUM_SRC];
  logic [NUM_SRC-1:0] OUT_stall;
  BranchProv          IN_branch;
  logic [NUM_BUS-1:0] OUT_resultValid;
  RES_UOp             OUT_resultUOp [NUM_BUS];

  modport master (
    output IN_valid, IN_res, IN_branch,
    input  OUT_stall, OUT_resultValid, OUT_resultUOp
  );

  modport slave (
    input  IN_valid, IN_res, IN_branch,
    output OUT_stall, OUT_resultValid, OUT_resultUOp
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// Buffers FU results in per-source FIFOs and broadcasts up to NUM_BUS per cycle, round-robin.
// Optional statistics counters are built when RESULT_ARB_STATS_EN is defined.
module result_bus_arbiter
  import result_bus_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int NUM_BUS    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  result_bus_arbiter_if.slave res_bus
`ifdef RESULT_ARB_STATS_EN
  ,
  output logic [31:0] OUT_statStallCycles [NUM_SRC],
  output logic [31:0] OUT_statFlushed
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BUS_W = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
  localparam int NG_W  = $clog2(NUM_BUS + 1);

  RES_UOp                mem     [NUM_SRC][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld [NUM_SRC];
  logic [FIFO_DEPTH-1:0] ent_hit [NUM_SRC];
  logic [PTR_W-1:0]      rd_ptr  [NUM_SRC];
  logic [PTR_W-1:0]      wr_ptr  [NUM_SRC];
  logic [CNT_W-1:0]      count   [NUM_SRC];
  logic [SRC_W-1:0]      rr;
  logic [SRC_W-1:0]      rr_next;

  logic [NUM_SRC-1:0] stall;
  logic [NUM_SRC-1:0] head_live;
  logic [NUM_SRC-1:0] head_dead;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] in_hit;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] pop;
  RES_UOp             head    [NUM_SRC];
  logic [NUM_BUS-1:0] bus_valid;
  logic [SRC_W-1:0]   bus_src [NUM_BUS];
  RES_UOp             bus_uop [NUM_BUS];
  logic [SRC_W-1:0]   last_src;
  logic               got_grant;

  // Younger than the branch means a positive wrapped distance in SqN arithmetic.
  function automatic logic is_younger(input logic [SQN_W-1:0] sq, input BranchProv br);
    logic [SQN_W-1:0] diff;
    diff = sq - br.sqN;
    return br.taken && !diff[SQN_W-1] && (diff != '0);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      stall[k]     = (count[k] == CNT_W'(FIFO_DEPTH));
      head[k]      = mem[k][rd_ptr[k]];
      head_live[k] = (count[k] != '0) && ent_vld[k][rd_ptr[k]]
                     && !is_younger(head[k].sqN, res_bus.IN_branch);
      head_dead[k] = (count[k] != '0) && !head_live[k];
      in_hit[k]    = res_bus.IN_valid[k] && !stall[k]
                     && is_younger(res_bus.IN_res[k].sqN, res_bus.IN_branch);
      push[k]      = res_bus.IN_valid[k] && !stall[k] && !in_hit[k];
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        ent_hit[k][d] = ent_vld[k][d] && is_younger(mem[k][d].sqN, res_bus.IN_branch);
      end
    end
  end

  assign res_bus.OUT_stall = stall;

  // Scan live heads from rr upward; the j-th winner drives bus j. Dead heads drain without a bus.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    logic [NG_W-1:0]  n_grant;
    grant     = '0;
    bus_valid = '0;
    last_src  = rr;
    got_grant = 1'b0;
    n_grant   = '0;
    sum       = '0;
    idx       = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      bus_src[b] = '0;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = {1'b0, rr} + (SRC_W+1)'(i);
      if (sum >= (SRC_W+1)'(NUM_SRC)) begin
        sum = sum - (SRC_W+1)'(NUM_SRC);
      end
      idx = sum[SRC_W-1:0];
      if (head_live[idx] && (n_grant < NG_W'(NUM_BUS))) begin
        grant[idx]                        = 1'b1;
        bus_valid[n_grant[BUS_W-1:0]]     = 1'b1;
        bus_src[n_grant[BUS_W-1:0]]       = idx;
        last_src                          = idx;
        got_grant                         = 1'b1;
        n_grant                           = n_grant + NG_W'(1);
      end
    end
    pop = grant | head_dead;
    if (!got_grant) begin
      rr_next = rr;
    end else if (last_src == SRC_W'(NUM_SRC - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = last_src + SRC_W'(1);
    end
    for (int b = 0; b < NUM_BUS; b++) begin
      bus_uop[b] = head[bus_src[b]];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rst && push[k]) begin
        mem[k][wr_ptr[k]] <= res_bus.IN_res[k];
      end
    end
  end

  // Pop clears the slot's valid bit, so a set bit always marks an occupied, live entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        rd_ptr[k]  <= '0;
        wr_ptr[k]  <= '0;
        count[k]   <= '0;
        ent_vld[k] <= '0;
      end
      rr <= '0;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        ent_vld[k] <= ent_vld[k] & ~ent_hit[k];
        if (pop[k]) begin
          ent_vld[k][rd_ptr[k]] <= 1'b0;
          rd_ptr[k]             <= rd_ptr[k] + PTR_W'(1);
        end
        if (push[k]) begin
          ent_vld[k][wr_ptr[k]] <= 1'b1;
          wr_ptr[k]             <= wr_ptr[k] + PTR_W'(1);
        end
        if (push[k] && !pop[k]) begin
          count[k] <= count[k] + CNT_W'(1);
        end else if (!push[k] && pop[k]) begin
          count[k] <= count[k] - CNT_W'(1);
        end
      end
      rr <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_bus.OUT_resultValid <= '0;
      for (int b = 0; b < NUM_BUS; b++) begin
        res_bus.OUT_resultUOp[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BUS; b++) begin
        res_bus.OUT_resultValid[b] <= bus_valid[b]
                                      && !is_younger(bus_uop[b].sqN, res_bus.IN_branch);
        if (bus_valid[b]) begin
          res_bus.OUT_resultUOp[b] <= bus_uop[b];
        end
      end
    end
  end

`ifdef RESULT_ARB_STATS_EN
  logic [31:0] flush_now;

  always_comb begin
    flush_now = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      flush_now = flush_now + 32'(in_hit[k]);
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        flush_now = flush_now + 32'(ent_hit[k][d]);
      end
    end
  end

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    logic [32:0] flush_sum;
    flush_sum = {1'b0, OUT_statFlushed} + {1'b0, flush_now};
    if (!rst) begin
      OUT_statFlushed <= '0;
      for (int k = 0; k < NUM_SRC; k++) begin
        OUT_statStallCycles[k] <= '0;
      end
    end else begin
      OUT_statFlushed <= flush_sum[32] ? '1 : flush_sum[31:0];
      for (int k = 0; k < NUM_SRC; k++) begin
        if (res_bus.IN_valid[k] && stall[k] && (OUT_statStallCycles[k] != '1)) begin
          OUT_statStallCycles[k] <= OUT_statStallCycles[k] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the per-source FIFOs and round-robin buses.
module tb_result_bus_arbiter;
  import result_bus_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int NUM_BUS = 2;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_bus_arbiter_if #(.NUM_SRC(NUM_SRC), .NUM_BUS(NUM_BUS)) rbus ();

`ifdef RESULT_ARB_STATS_EN
  logic [31:0] stat_stall [NUM_SRC];
  logic [31:0] stat_flushed;
`endif

  result_bus_arbiter #(.NUM_SRC(NUM_SRC), .NUM_BUS(NUM_BUS), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .res_bus (rbus)
`ifdef RESULT_ARB_STATS_EN
    ,
    .OUT_statStallCycles (stat_stall),
    .OUT_statFlushed     (stat_flushed)
`endif
  );

  typedef struct {
    RES_UOp uop;
    bit     live;
  } ent_t;

  ent_t       mq [NUM_SRC][$];
  int         m_rr;
  RES_UOp     m_out  [NUM_BUS];
  bit         m_outv [NUM_BUS];
  int         m_stall_cnt [NUM_SRC];
  int         m_flushed;
  logic [6:0] next_sq;
  int         checks = 0;
  int         errors = 0;

  function automatic bit younger_ref(logic [6:0] sq, logic [6:0] br);
    logic [6:0] d;
    d = sq - br;
    return $signed(d) > 0;
  endfunction

  function automatic logic [NUM_SRC-1:0] model_stall();
    logic [NUM_SRC-1:0] s;
    for (int k = 0; k < NUM_SRC; k++) s[k] = (mq[k].size() == DEPTH);
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_SRC; k++) begin
      mq[k].delete();
      m_stall_cnt[k] = 0;
    end
    for (int b = 0; b < NUM_BUS; b++) begin
      m_out[b]  = '0;
      m_outv[b] = 1'b0;
    end
    m_rr      = 0;
    m_flushed = 0;
  endtask

  // One clock of the reference behaviour, driven by whatever is on the inputs right now.
  task automatic model_step();
    logic [NUM_SRC-1:0] st;
    bit dead  [NUM_SRC];
    bit grant [NUM_SRC];
    int n, last;
    bit got;
    ent_t e;
    st = model_stall();
    if (rbus.IN_branch.taken) begin
      for (int k = 0; k < NUM_SRC; k++)
        for (int i = 0; i < mq[k].size(); i++)
          if (mq[k][i].live && younger_ref(mq[k][i].uop.sqN, rbus.IN_branch.sqN)) begin
            mq[k][i].live = 1'b0;
            m_flushed++;
          end
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      dead[k]  = (mq[k].size() > 0) && !mq[k][0].live;
      grant[k] = 1'b0;
    end
    n = 0; last = 0; got = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int idx;
      idx = (m_rr + i) % NUM_SRC;
      if (n < NUM_BUS && mq[idx].size() > 0 && mq[idx][0].live) begin
        grant[idx] = 1'b1;
        m_out[n]   = mq[idx][0].uop;
        m_outv[n]  = 1'b1;
        n++;
        last = idx;
        got  = 1'b1;
      end
    end
    for (int b = n; b < NUM_BUS; b++) m_outv[b] = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      if (grant[k] || dead[k]) void'(mq[k].pop_front());
    for (int k = 0; k < NUM_SRC; k++) begin
      if (rbus.IN_valid[k]) begin
        if (st[k]) m_stall_cnt[k]++;
        else if (rbus.IN_branch.taken && younger_ref(rbus.IN_res[k].sqN, rbus.IN_branch.sqN))
          m_flushed++;
        else begin
          e.uop  = rbus.IN_res[k];
          e.live = 1'b1;
          mq[k].push_back(e);
        end
      end
    end
    if (got) m_rr = (last + 1) % NUM_SRC;
  endtask

  task automatic clear_inputs();
    rbus.IN_valid  = '0;
    rbus.IN_branch = '0;
    for (int k = 0; k < NUM_SRC; k++) rbus.IN_res[k] = '0;
  endtask

  task automatic set_src(int k, logic [6:0] tag, logic [6:0] sq);
    rbus.IN_valid[k]         = 1'b1;
    rbus.IN_res[k].tagDst    = tag;
    rbus.IN_res[k].nmDst     = tag[5:0];
    rbus.IN_res[k].sqN       = sq;
    rbus.IN_res[k].result    = $urandom;
    rbus.IN_res[k].flags     = 4'($urandom);
  endtask

  task automatic set_branch(logic [6:0] sq);
    rbus.IN_branch.taken = 1'b1;
    rbus.IN_branch.sqN   = sq;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL reset_valid: got %b expected 00", rbus.OUT_resultValid);
    end
    checks++;
    if (rbus.OUT_stall !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_stall: got %b expected 0000", rbus.OUT_stall);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    set_src(0, 7'd7, 7'd1);
    tick();
    clear_inputs();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL single_early: got %b expected 00", rbus.OUT_resultValid);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b01 || rbus.OUT_resultUOp[0].tagDst !== 7'd7) begin
      errors++;
      $display("[TB] FAIL single_bus0: got valid %b tag %0d expected valid 01 tag 7",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].tagDst);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL single_after: got %b expected 00", rbus.OUT_resultValid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < NUM_SRC; k++) set_src(k, 7'(10 + k), 7'(k + 1));
    tick();
    clear_inputs();
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b11 || rbus.OUT_resultUOp[0].tagDst !== 7'd10
        || rbus.OUT_resultUOp[1].tagDst !== 7'd11) begin
      errors++;
      $display("[TB] FAIL rr_first: got valid %b tags %0d/%0d expected 11 tags 10/11",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].tagDst, rbus.OUT_resultUOp[1].tagDst);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b11 || rbus.OUT_resultUOp[0].tagDst !== 7'd12
        || rbus.OUT_resultUOp[1].tagDst !== 7'd13) begin
      errors++;
      $display("[TB] FAIL rr_second: got valid %b tags %0d/%0d expected 11 tags 12/13",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].tagDst, rbus.OUT_resultUOp[1].tagDst);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00 || rbus.OUT_resultUOp[0].tagDst !== 7'd12) begin
      errors++;
      $display("[TB] FAIL rr_idle_hold: got valid %b tag %0d expected 00 tag 12",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].tagDst);
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_SRC-1:0] exp_st [4];
    int bcast, tag_sum;
    exp_st = '{4'b0000, 4'b1100, 4'b0011, 4'b1100};
    do_reset();
    bcast = 0; tag_sum = 0;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      for (int k = 0; k < NUM_SRC; k++) set_src(k, 7'(4 * c + k), 7'(4 * c + k));
      tick();
      checks++;
      if (rbus.OUT_stall !== exp_st[c]) begin
        errors++;
        $display("[TB] FAIL stall_edge%0d: got %b expected %b", c + 1, rbus.OUT_stall, exp_st[c]);
      end
      for (int b = 0; b < NUM_BUS; b++)
        if (rbus.OUT_resultValid[b]) begin bcast++; tag_sum += rbus.OUT_resultUOp[b].tagDst; end
    end
    clear_inputs();
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int b = 0; b < NUM_BUS; b++)
        if (rbus.OUT_resultValid[b]) begin bcast++; tag_sum += rbus.OUT_resultUOp[b].tagDst; end
    end
    checks++;
    if (bcast != 12 || tag_sum != 74) begin
      errors++;
      $display("[TB] FAIL backpressure_drain: got %0d results tag sum %0d expected 12 sum 74",
               bcast, tag_sum);
    end
  endtask

  task automatic test_branch_flush();
    int late;
    do_reset();
    set_src(0, 7'd1, 7'd10);
    set_src(1, 7'd2, 7'd12);
    set_src(2, 7'd3, 7'd15);
    tick();
    clear_inputs();
    set_branch(7'd12);
    set_src(0, 7'd4, 7'd11);
    set_src(3, 7'd5, 7'd13);
    tick();
    clear_inputs();
    checks++;
    if (rbus.OUT_resultValid !== 2'b11 || rbus.OUT_resultUOp[0].sqN !== 7'd10
        || rbus.OUT_resultUOp[1].sqN !== 7'd12) begin
      errors++;
      $display("[TB] FAIL flush_older: got valid %b sqN %0d/%0d expected 11 sqN 10/12",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].sqN, rbus.OUT_resultUOp[1].sqN);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b01 || rbus.OUT_resultUOp[0].sqN !== 7'd11) begin
      errors++;
      $display("[TB] FAIL flush_push_older: got valid %b sqN %0d expected 01 sqN 11",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].sqN);
    end
    late = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (rbus.OUT_resultValid !== 2'b00) late++;
    end
    checks++;
    if (late != 0) begin
      errors++; $display("[TB] FAIL flush_young_gone: got %0d late broadcasts expected 0", late);
    end
  endtask

  task automatic test_output_flush();
    do_reset();
    set_src(0, 7'd20, 7'd20);
    tick();
    clear_inputs();
    set_src(0, 7'd21, 7'd21);
    tick();
    clear_inputs();
    checks++;
    if (rbus.OUT_resultValid !== 2'b01 || rbus.OUT_resultUOp[0].sqN !== 7'd20) begin
      errors++;
      $display("[TB] FAIL outreg_hold: got valid %b sqN %0d expected 01 sqN 20",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].sqN);
    end
    set_branch(7'd18);
    tick();
    clear_inputs();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL outreg_flush: got %b expected 00", rbus.OUT_resultValid);
    end
    set_src(2, 7'd30, 7'h01);
    set_src(3, 7'd31, 7'h7E);
    tick();
    clear_inputs();
    set_branch(7'h7F);
    tick();
    clear_inputs();
    checks++;
    if (rbus.OUT_resultValid !== 2'b01 || rbus.OUT_resultUOp[0].sqN !== 7'h7E) begin
      errors++;
      $display("[TB] FAIL wrap_flush: got valid %b sqN %0h expected 01 sqN 7e",
               rbus.OUT_resultValid, rbus.OUT_resultUOp[0].sqN);
    end
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL wrap_gone: got %b expected 00", rbus.OUT_resultValid);
    end
  endtask

  task automatic test_random();
    logic [6:0] br;
    do_reset();
    next_sq = 7'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_inputs();
      for (int k = 0; k < NUM_SRC; k++)
        if ($urandom_range(99) < 60) begin
          set_src(k, 7'($urandom), next_sq);
          next_sq = next_sq + 7'd1;
        end
      if ($urandom_range(11) == 0) begin
        br = next_sq - 7'($urandom_range(8, 1));
        set_branch(br);
        next_sq = br + 7'd1;
      end
      tick();
      checks++;
      if (rbus.OUT_stall !== model_stall()) begin
        errors++;
        $display("[TB] FAIL rand_stall c%0d: got %b expected %b", cyc, rbus.OUT_stall, model_stall());
      end
      for (int b = 0; b < NUM_BUS; b++) begin
        checks++;
        if (rbus.OUT_resultValid[b] !== m_outv[b] || rbus.OUT_resultUOp[b] !== m_out[b]) begin
          errors++;
          $display("[TB] FAIL rand_bus%0d c%0d: got v%b %h expected v%b %h", b, cyc,
                   rbus.OUT_resultValid[b], rbus.OUT_resultUOp[b], m_outv[b], m_out[b]);
        end
      end
    end
`ifdef RESULT_ARB_STATS_EN
    for (int k = 0; k < NUM_SRC; k++) begin
      checks++;
      if (stat_stall[k] !== 32'(m_stall_cnt[k])) begin
        errors++;
        $display("[TB] FAIL stat_stall%0d: got %0d expected %0d", k, stat_stall[k], m_stall_cnt[k]);
      end
    end
    checks++;
    if (stat_flushed !== 32'(m_flushed)) begin
      errors++; $display("[TB] FAIL stat_flushed: got %0d expected %0d", stat_flushed, m_flushed);
    end
`endif
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      for (int k = 0; k < NUM_SRC; k++) set_src(k, 7'(c * 4 + k), 7'(c * 4 + k));
      tick();
    end
    checks++;
    if (rbus.OUT_stall !== 4'b0011) begin
      errors++; $display("[TB] FAIL pre_reset_full: got %b expected 0011", rbus.OUT_stall);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00 || rbus.OUT_stall !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_reset: got valid %b stall %b expected 00 0000",
               rbus.OUT_resultValid, rbus.OUT_stall);
    end
`ifdef RESULT_ARB_STATS_EN
    checks++;
    if (stat_flushed !== 32'd0 || stat_stall[0] !== 32'd0 || stat_stall[1] !== 32'd0
        || stat_stall[2] !== 32'd0 || stat_stall[3] !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_reset_stats: got flushed %0d expected 0", stat_flushed);
    end
`endif
    clear_inputs();
    tick();
    checks++;
    if (rbus.OUT_resultValid !== 2'b00) begin
      errors++; $display("[TB] FAIL post_reset_idle: got %b expected 00", rbus.OUT_resultValid);
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single_push();
    test_back_to_back();
    test_backpressure();
    test_branch_flush();
    test_output_flush();
    test_random();
    test_reset_mid_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
